// File: rtl/spio_spinnaker_link_rx_arbiter.sv
// Round-robin arbiter sharing one 2-of-7 flit deserializer between NUM_LINKS
// link FIFOs; a grant is held until EOP. Optional stall timeout: SPIO_RX_ARB_TIMEOUT_EN.
module spio_spinnaker_link_rx_arbiter #(
  parameter int unsigned NUM_LINKS = 4,
  parameter int unsigned LINK_BITS = 2,
  parameter int unsigned TO_BITS   = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic                   CLK_IN,
  input  logic                   rst,
  input  logic [7*NUM_LINKS-1:0] flt_data_in,
  input  logic [NUM_LINKS-1:0]   flt_vld_in,
  output logic [NUM_LINKS-1:0]   flt_rdy_out,
  output logic [6:0]             out_data_2of7,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LINK_BITS-1:0]   out_link,
  output logic                   timeout_out
);

  localparam logic [6:0] EOP = 7'b1100000;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [LINK_BITS-1:0] ptr_q, ptr_d;
  logic [LINK_BITS-1:0] grant_q, grant_d;
  logic [6:0]           data_q;
  logic                 vld_q;
  logic [LINK_BITS-1:0] link_q;

  logic                 out_free;
  logic                 take;
  logic                 revoke;
  logic [6:0]           flit;
  logic                 found;
  logic [LINK_BITS-1:0] cand;

  assign out_free = !vld_q || out_rdy;
  assign flit     = flt_data_in[7*grant_q +: 7];
  assign take     = (state_q == BUSY) && flt_vld_in[grant_q] && out_free;

  assign out_data_2of7 = data_q;
  assign out_vld       = vld_q;
  assign out_link      = link_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    found       = 1'b0;
    cand        = '0;
    flt_rdy_out = '0;
    if (state_q == IDLE) begin
      // Scan starts one past the last served link, so it gets lowest priority.
      for (int unsigned k = 1; k <= NUM_LINKS; k++) begin
        cand = LINK_BITS'((ptr_q + k) % NUM_LINKS);
        if (!found && flt_vld_in[cand]) begin
          found   = 1'b1;
          grant_d = cand;
          state_d = BUSY;
        end
      end
    end else begin
      flt_rdy_out[grant_q] = out_free;
      if ((take && flit == EOP) || revoke) begin
        state_d = IDLE;
        ptr_d   = grant_q;
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= LINK_BITS'(NUM_LINKS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Output register drains on its own, independent of arbitration state.
  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      link_q <= '0;
    end else if (take) begin
      data_q <= flit;
      vld_q  <= 1'b1;
      link_q <= grant_q;
    end else if (out_rdy) begin
      vld_q  <= 1'b0;
    end
  end

`ifdef SPIO_RX_ARB_TIMEOUT_EN
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               stalled;

  // Only an upstream stall counts; a full output register holds the count.
  assign stalled     = (state_q == BUSY) && !flt_vld_in[grant_q];
  assign revoke      = stalled && (cnt_q == TO_BITS'(TIMEOUT - 1));
  assign timeout_out = revoke;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY || take || revoke) cnt_d = '0;
    else if (stalled)                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign revoke      = 1'b0;
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_rx_arbiter.sv
// Scoreboard bench for spio_spinnaker_link_rx_arbiter: per-link flit queues feed
// the DUT, expected (link, flit) pairs are queued in predicted order.
module tb_spio_spinnaker_link_rx_arbiter;

  logic        CLK_IN;
  logic        rst;
  logic [27:0] flt_data_in;
  logic [3:0]  flt_vld_in;
  logic [3:0]  flt_rdy_out;
  logic [6:0]  out_data_2of7;
  logic        out_vld;
  logic        out_rdy;
  logic [1:0]  out_link;
  logic        timeout_out;

  spio_spinnaker_link_rx_arbiter #(
    .NUM_LINKS(4),
    .LINK_BITS(2),
    .TO_BITS  (8),
    .TIMEOUT  (200)
  ) dut (
    .CLK_IN       (CLK_IN),
    .rst          (rst),
    .flt_data_in  (flt_data_in),
    .flt_vld_in   (flt_vld_in),
    .flt_rdy_out  (flt_rdy_out),
    .out_data_2of7(out_data_2of7),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_link     (out_link),
    .timeout_out  (timeout_out)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] sb[$];
  logic [6:0] lq[4][$];
  logic [3:0] last_rdy;
  logic [3:0] fire;
  logic       last_to;

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Output side: each accepted output flit must match the scoreboard head.
  always @(negedge CLK_IN) begin
    logic [8:0] exp;
    #2;
    if (!rst && out_vld && out_rdy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got link=%0d data=%b want nothing", out_link, out_data_2of7);
      end else begin
        exp = sb.pop_front();
        if ({out_link, out_data_2of7} !== exp) begin
          bad++;
          $display("FAIL sb_out got link=%0d data=%b want link=%0d data=%b",
                   out_link, out_data_2of7, exp[8:7], exp[6:0]);
        end
      end
    end
  end

  function automatic void expect_flit(input int link, input logic [6:0] d);
    sb.push_back({2'(link), d});
  endfunction

  // One clock: present queue heads, sample ready before the edge, pop accepted flits.
  task automatic cycle();
    logic [3:0]  v;
    logic [27:0] d;
    @(negedge CLK_IN);
    v = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (lq[i].size() > 0) begin
        v[i]       = 1'b1;
        d[7*i +: 7] = lq[i][0];
      end
    end
    flt_vld_in  = v;
    flt_data_in = d;
    #3;
    last_rdy = flt_rdy_out;
    last_to  = timeout_out;
    fire     = flt_vld_in & flt_rdy_out;
    @(posedge CLK_IN);
    for (int i = 0; i < 4; i++)
      if (fire[i]) void'(lq[i].pop_front());
    #1;
  endtask

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      cycle();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    out_rdy     = 1'b1;
    flt_vld_in  = 4'b1111;
    flt_data_in = {4{7'b0000011}};
    repeat (2) @(negedge CLK_IN);
    #3;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got %b want 0", out_vld); end
    total++; if (out_data_2of7 !== 7'd0) begin bad++; $display("FAIL rst_data got %b want 0", out_data_2of7); end
    total++; if (out_link !== 2'd0) begin bad++; $display("FAIL rst_link got %0d want 0", out_link); end
    total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL rst_timeout got %b want 0", timeout_out); end
    total++; if (flt_rdy_out !== 4'b0000) begin bad++; $display("FAIL rst_rdy got %b want 0000", flt_rdy_out); end
    @(posedge CLK_IN);
    #1;
    flt_vld_in = '0;
    rst        = 1'b0;
  endtask

  task automatic test_single_packet();
    expect_flit(0, 7'b0000011);
    expect_flit(0, 7'b0000101);
    expect_flit(0, 7'b1100000);
    lq[0].push_back(7'b0000011);
    lq[0].push_back(7'b0000101);
    lq[0].push_back(7'b1100000);
    drain(30, "t1");
    // Back in IDLE: one bubble before the next grant raises ready.
    expect_flit(0, 7'b1100000);
    lq[0].push_back(7'b1100000);
    cycle();
    total++; if (last_rdy !== 4'b0000) begin bad++; $display("FAIL t1_idle_bubble got %b want 0000", last_rdy); end
    cycle();
    total++; if (last_rdy !== 4'b0001) begin bad++; $display("FAIL t1_grant_rdy got %b want 0001", last_rdy); end
    drain(10, "t1b");
  endtask

  task automatic test_round_robin();
    expect_flit(1, 7'b0000011);
    expect_flit(1, 7'b1100000);
    expect_flit(2, 7'b1111111);
    expect_flit(2, 7'b0000101);
    expect_flit(2, 7'b1100000);
    lq[1].push_back(7'b0000011);
    lq[1].push_back(7'b1100000);
    lq[2].push_back(7'b1111111);
    lq[2].push_back(7'b0000101);
    lq[2].push_back(7'b1100000);
    drain(40, "t2");
  endtask

  task automatic test_backpressure();
    int n = 0;
    expect_flit(3, 7'b0000011);
    expect_flit(3, 7'b0000101);
    expect_flit(3, 7'b0000110);
    expect_flit(3, 7'b1100000);
    lq[3].push_back(7'b0000011);
    lq[3].push_back(7'b0000101);
    lq[3].push_back(7'b0000110);
    lq[3].push_back(7'b1100000);
    while (sb.size() > 2 && n < 20) begin
      cycle();
      n++;
    end
    out_rdy = 1'b0;
    repeat (5) begin
      cycle();
      total++;
      if (out_vld !== 1'b1 || out_data_2of7 !== 7'b0000110 || out_link !== 2'd3) begin
        bad++;
        $display("FAIL t3_hold got vld=%b data=%b link=%0d want vld=1 data=0000110 link=3",
                 out_vld, out_data_2of7, out_link);
      end
      total++; if (last_rdy !== 4'b0000) begin bad++; $display("FAIL t3_rdy got %b want 0000", last_rdy); end
    end
    out_rdy = 1'b1;
    drain(20, "t3");
  endtask

  task automatic test_stall();
    int n = 0;
`ifdef SPIO_RX_ARB_TIMEOUT_EN
    int stalled = 0;
    expect_flit(3, 7'b0000011);
    expect_flit(0, 7'b1100000);
    lq[3].push_back(7'b0000011);
    while (lq[3].size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    lq[0].push_back(7'b1100000);
    last_to = 1'b0;
    while (!last_to && stalled < 300) begin
      cycle();
      stalled++;
    end
    total++; if (stalled !== 200) begin bad++; $display("FAIL t4_timeout_cycle got %0d want 200", stalled); end
    cycle();
    total++; if (last_to !== 1'b0) begin bad++; $display("FAIL t4_pulse_width got %b want 0", last_to); end
    drain(20, "t4");
`else
    logic to_seen  = 1'b0;
    logic rdy0_seen = 1'b0;
    expect_flit(3, 7'b0000011);
    expect_flit(3, 7'b1100000);
    expect_flit(0, 7'b1100000);
    lq[3].push_back(7'b0000011);
    while (lq[3].size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    lq[0].push_back(7'b1100000);
    repeat (250) begin
      cycle();
      to_seen   = to_seen | last_to;
      rdy0_seen = rdy0_seen | last_rdy[0];
    end
    total++; if (to_seen !== 1'b0) begin bad++; $display("FAIL t4_no_timeout got %b want 0", to_seen); end
    total++; if (rdy0_seen !== 1'b0) begin bad++; $display("FAIL t4_grant_held got %b want 0", rdy0_seen); end
    lq[3].push_back(7'b1100000);
    drain(20, "t4");
`endif
  endtask

  task automatic test_reset_mid_packet();
    expect_flit(2, 7'b0000011);
    expect_flit(2, 7'b0000101);
    lq[2].push_back(7'b0000011);
    lq[2].push_back(7'b0000101);
    lq[2].push_back(7'b0000110);
    lq[2].push_back(7'b1100000);
    drain(20, "t5a");
    rst = 1'b1;
    #1;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL t5_vld got %b want 0", out_vld); end
    total++; if (flt_rdy_out !== 4'b0000) begin bad++; $display("FAIL t5_rdy got %b want 0000", flt_rdy_out); end
    lq[2].delete();
    expect_flit(0, 7'b1100000);
    expect_flit(2, 7'b1100000);
    lq[2].push_back(7'b1100000);
    lq[0].push_back(7'b1100000);
    repeat (2) cycle();
    total++; if (last_rdy !== 4'b0000) begin bad++; $display("FAIL t5_rdy_in_rst got %b want 0000", last_rdy); end
    rst = 1'b0;
    drain(20, "t5b");
  endtask

  task automatic test_back_to_back();
    logic [6:0] d0 [3];
    logic [6:0] d1 [3];
    d0[0] = 7'b0000011; d0[1] = 7'b0000101; d0[2] = 7'b0000110;
    d1[0] = 7'b0001001; d1[1] = 7'b0001010; d1[2] = 7'b0001100;
    for (int p = 0; p < 3; p++) begin
      lq[0].push_back(d0[p]); lq[0].push_back(7'b1100000);
      lq[1].push_back(d1[p]); lq[1].push_back(7'b1100000);
      expect_flit(0, d0[p]); expect_flit(0, 7'b1100000);
      expect_flit(1, d1[p]); expect_flit(1, 7'b1100000);
    end
    drain(80, "t6");
  endtask

  task automatic test_eop_held();
    out_rdy = 1'b0;
    expect_flit(2, 7'b1100000);
    expect_flit(3, 7'b0000011);
    expect_flit(3, 7'b1100000);
    lq[2].push_back(7'b1100000);
    lq[3].push_back(7'b0000011);
    lq[3].push_back(7'b1100000);
    repeat (5) cycle();
    total++; if (lq[3].size() !== 2) begin bad++; $display("FAIL t7_no_take got %0d want 2", lq[3].size()); end
    out_rdy = 1'b1;
    cycle();
    total++; if (last_rdy !== 4'b1000) begin bad++; $display("FAIL t7_early_grant got %b want 1000", last_rdy); end
    drain(20, "t7");
  endtask

  initial begin
    flt_vld_in  = '0;
    flt_data_in = '0;
    out_rdy     = 1'b1;
    rst         = 1'b1;
    last_rdy    = '0;
    last_to     = 1'b0;
    fire        = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_reset_mid_packet();
    test_back_to_back();
    test_eop_held();
    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
